// File: rtl/pu_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared fixed-latency processing unit.
// It grants one requester per cycle, forwards that requester's operands, and tags each returning result with its owner.
module pu_issue_arbiter #(
    parameter int XLEN   = 5,
    parameter int NREQ   = 4,
    parameter int PU_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*4*XLEN-1:0]    op_bus,
    input  logic                      issue_en,
    output logic [NREQ-1:0]           gnt,
    output logic [XLEN-1:0]           pu_num1,
    output logic [XLEN-1:0]           pu_num2,
    output logic [XLEN-1:0]           pu_num3,
    output logic [XLEN-1:0]           pu_num4,
    input  logic [XLEN-1:0]           pu_result,
    output logic                      res_valid,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [XLEN-1:0]           res_data,
    output logic                      busy
);
    localparam int IDW = $clog2(NREQ);

    // Handshake: a requester holds req and its operands until gnt is seen.
    // gnt high means the operation is taken at this cycle's rising edge.
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PU_LAT-1:0] vld_q, vld_d;
    logic [IDW-1:0]    id_q [PU_LAT];
    logic [IDW-1:0]    id_d [PU_LAT];

    logic              gnt_any;
    logic [IDW-1:0]    gnt_idx;
    int                idx;
    logic [XLEN-1:0]   nums [4];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        // Reset also gates the grant so nothing issues while the pipeline is cleared.
        if (issue_en && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!gnt_any && req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < 4; k++) begin
            nums[k] = '0;
        end
        if (gnt_any) begin
            gnt = NREQ'(1) << gnt_idx;
            for (int k = 0; k < 4; k++) begin
                nums[k] = op_bus[(4 * int'(gnt_idx) + k) * XLEN +: XLEN];
            end
        end
    end

    assign pu_num1 = nums[0];
    assign pu_num2 = nums[1];
    assign pu_num3 = nums[2];
    assign pu_num4 = nums[3];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
        end
        vld_d    = '0;
        vld_d[0] = gnt_any;
        id_d[0]  = gnt_any ? gnt_idx : '0;
        for (int s = 1; s < PU_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            for (int s = 0; s < PU_LAT; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            for (int s = 0; s < PU_LAT; s++) begin
                id_q[s] <= id_d[s];
            end
        end
    end

    assign res_valid = vld_q[PU_LAT-1];
    assign res_id    = id_q[PU_LAT-1];
    assign res_data  = res_valid ? pu_result : '0;
    assign busy      = |vld_q;
endmodule

// File: tb/tb_pu_issue_arbiter.sv
// Bench for pu_issue_arbiter: directed scenarios plus random traffic.
// Expected results are queued at grant time and retired when their result cycle arrives.
module tb_pu_issue_arbiter;
    localparam int XLEN   = 5;
    localparam int NREQ   = 4;
    localparam int PU_LAT = 2;
    localparam int W      = 18;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*4*XLEN-1:0] op_bus;
    logic                   issue_en;
    logic [NREQ-1:0]        gnt;
    logic [XLEN-1:0]        pu_num1, pu_num2, pu_num3, pu_num4;
    logic [XLEN-1:0]        pu_result;
    logic                   res_valid;
    logic [1:0]             res_id;
    logic [XLEN-1:0]        res_data;
    logic                   busy;

    logic [W-1:0]    exp_q[$];
    logic [XLEN-1:0] ops [NREQ][4];
    int              model_ptr = 0;
    int              cyc = 0;
    int              vectors = 0;
    int              errors = 0;

    pu_issue_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .PU_LAT(PU_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_bus(op_bus), .issue_en(issue_en),
        .gnt(gnt), .pu_num1(pu_num1), .pu_num2(pu_num2), .pu_num3(pu_num3),
        .pu_num4(pu_num4), .pu_result(pu_result), .res_valid(res_valid),
        .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input logic en, input int p);
        if (!en) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++)
                op_bus[(4*i+k)*XLEN +: XLEN] = ops[i][k];
    endtask

    // One clock cycle: drive, then check grant/operands/result against the model and scoreboard.
    task automatic do_cycle(input logic [NREQ-1:0] r, input logic en, output logic [NREQ-1:0] g_obs);
        int              g;
        logic [NREQ-1:0] exp_gnt;
        logic [XLEN-1:0] exp_num [4];
        logic [XLEN-1:0] obs_num [4];
        logic            exp_busy, exp_rv;
        logic [1:0]      exp_id;
        logic [W-1:0]    head;
        @(posedge clk);
        #1;
        req       = r;
        issue_en  = en;
        pu_result = XLEN'($urandom_range(0, 31));
        load_ops();
        #3;
        g       = rr_pick(r, en, model_ptr);
        exp_gnt = (g >= 0) ? NREQ'(1) << g : '0;
        for (int k = 0; k < 4; k++) exp_num[k] = (g >= 0) ? ops[g][k] : '0;
        obs_num[0] = pu_num1; obs_num[1] = pu_num2; obs_num[2] = pu_num3; obs_num[3] = pu_num4;
        g_obs = gnt;
        vectors++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs_num[k] !== exp_num[k]) begin
                errors++;
                $display("FAIL pu_num%0d cyc=%0d got=%0d exp=%0d", k+1, cyc, obs_num[k], exp_num[k]);
            end
        end
        exp_busy = (exp_q.size() != 0);
        exp_rv   = 1'b0;
        exp_id   = 2'd0;
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            if (int'(head[W-1:2]) == cyc) begin
                exp_rv = 1'b1;
                exp_id = head[1:0];
                void'(exp_q.pop_front());
            end
        end
        vectors++;
        if (res_valid !== exp_rv || (exp_rv && res_id !== exp_id)) begin
            errors++;
            $display("FAIL res cyc=%0d got v=%b id=%0d exp v=%b id=%0d", cyc, res_valid, res_id, exp_rv, exp_id);
        end
        vectors++;
        if (res_data !== (exp_rv ? pu_result : '0)) begin
            errors++;
            $display("FAIL res_data cyc=%0d got=%0d exp=%0d", cyc, res_data, exp_rv ? pu_result : '0);
        end
        vectors++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        if (g >= 0) begin
            exp_q.push_back({16'(cyc + PU_LAT), 2'(g)});
            model_ptr = (g + 1) % NREQ;
            for (int k = 0; k < 4; k++) ops[g][k] = XLEN'($urandom_range(0, 31));
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        model_ptr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        issue_en = 1'b1;
        pu_result = 5'd17;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) ops[i][k] = XLEN'(i * 4 + k + 1);
        load_ops();
        #2;
        vectors++;
        if (gnt !== 4'b0 || pu_num1 !== 5'd0 || pu_num2 !== 5'd0 || pu_num3 !== 5'd0 || pu_num4 !== 5'd0) begin
            errors++;
            $display("FAIL reset_gnt got gnt=%b num1=%0d exp gnt=0 num=0", gnt, pu_num1);
        end
        vectors++;
        if (res_valid !== 1'b0 || res_id !== 2'd0 || res_data !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got v=%b id=%0d d=%0d busy=%b exp all 0", res_valid, res_id, res_data, busy);
        end
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [NREQ-1:0] g;
        for (int i = 0; i < 5; i++) do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        apply_reset();
        ops[1][0] = 5'd1; ops[1][1] = 5'd2; ops[1][2] = 5'd3; ops[1][3] = 5'd4;
        do_cycle(4'b0010, 1'b1, g);
        vectors++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL single_gnt got=%b exp=0010", g);
        end
        do_cycle(4'b0000, 1'b1, g);
        do_cycle(4'b0000, 1'b1, g);
        vectors++;
        if (res_valid !== 1'b1 || res_id !== 2'd1) begin
            errors++;
            $display("FAIL single_res got v=%b id=%0d exp v=1 id=1", res_valid, res_id);
        end
        do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_cycle(4'b1111, 1'b1, g);
            vectors++;
            if (g !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", i, g, exp_seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_ptr_wrap();
        logic [NREQ-1:0] g;
        apply_reset();
        do_cycle(4'b0001, 1'b1, g);
        do_cycle(4'b0101, 1'b1, g);
        vectors++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_first got=%b exp=0100", g);
        end
        do_cycle(4'b0101, 1'b1, g);
        vectors++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_second got=%b exp=0001", g);
        end
        do_cycle(4'b1111, 1'b1, g);
        vectors++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_end got=%b exp=0010", g);
        end
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_issue_en();
        logic [NREQ-1:0] g;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_cycle(4'b1111, (i == 2 || i == 3) ? 1'b0 : 1'b1, g);
            if (i == 4) begin
                vectors++;
                if (g !== 4'b0100) begin
                    errors++;
                    $display("FAIL en_resume got=%b exp=0100", g);
                end
            end
        end
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_flight_reset();
        logic [NREQ-1:0] g;
        apply_reset();
        do_cycle(4'b1111, 1'b1, g);
        do_cycle(4'b1111, 1'b1, g);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL flight_rst got v=%b busy=%b gnt=%b exp 0", res_valid, busy, gnt);
        end
        exp_q.delete();
        model_ptr = 0;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_cycle(4'b0000, 1'b1, g);
        do_cycle(4'b0000, 1'b1, g);
        do_cycle(4'b1111, 1'b1, g);
        vectors++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL flight_first got=%b exp=0001", g);
        end
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 1'b1, g);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        apply_reset();
        for (int i = 0; i < 300; i++)
            do_cycle(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), g);
        for (int i = 0; i < PU_LAT + 1; i++) do_cycle(4'b0000, 1'b1, g);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_ptr_wrap();
        test_issue_en();
        test_flight_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
